pipe_deser: RTL and testbench
=============================

# pipe_deser

Serial-to-parallel deserializer that sits directly downstream of the `pipe` shift stage. It consumes the LSB-first bit stream that `pipe` emits on `o_bit`, qualified by the same clock-enable strobe. It assembles LN-bit words and hands them to the next stage through a 2-entry valid/ready output buffer. Words that arrive while the buffer is full are dropped, and a sticky overflow flag records the loss.

## Interface

- `LN`, default 8: word width in bits, LN >= 2.
- `i_clk`, input, 1: system clock; all state changes on the rising edge.
- `i_reset_n`, input, 1: asynchronous active-low reset.
- `i_ce`, input, 1: bit strobe; `i_bit` is sampled only when high.
- `i_bit`, input, 1: serial data, LSB first; driven from `pipe.o_bit`.
- `i_sync`, input, 1: word-alignment restart; discards any partial word.
- `i_clr_ovf`, input, 1: clears `o_overflow`.
- `o_valid`, output, 1: buffer holds at least one word.
- `i_ready`, input, 1: consumer accepts the head word when it is high together with `o_valid`.
- `o_word`, output, LN: head word of the buffer.
- `o_overflow`, output, 1: sticky flag; at least one completed word was dropped.

## Operation

**Assembly**
- `acc[LN-1:0]` and `cnt` (0..LN-1) hold the partial word.
- On `i_ce`: `acc <= {i_bit, acc[LN-1:1]}`. This is the same shift direction as `pipe`, so bit 0 of the word is the first bit received.
- `cnt` increments on each `i_ce` and wraps LN-1 -> 0.
- Word complete: `i_ce` is high while `cnt == LN-1`. The pushed word is `{i_bit, acc[LN-1:1]}`.
- With `i_ce` low, `acc` and `cnt` hold and `i_bit` is ignored.

**Realignment**
- `i_sync` without `i_ce`: `cnt <= 0`; `acc` contents are don't-care.
- `i_sync` with `i_ce`: the current `i_bit` becomes bit 0 of a new word and `cnt <= 1`.
- `i_sync` never generates a push.

**Output buffer (2 entries, FIFO order)**
- Push: a word completes.
- Pop: `o_valid && i_ready`.
- `o_valid` = buffer not empty. `o_word` = head entry, and is 0 when empty.
- Push when full with no pop in the same cycle: the word is dropped and `o_overflow <= 1`. Buffer contents are unchanged.
- Push and pop together when full: both take effect. Occupancy stays 2, the new word goes to the tail, and no overflow is flagged.
- Push and pop together with 1 entry: the new word becomes the head; occupancy stays 1.
- Pop when empty: impossible, because `o_valid` is 0.

**Overflow flag**
- `o_overflow` is set by a drop and cleared by `i_clr_ovf`.
- If a drop and `i_clr_ovf` occur in the same cycle, set wins and the flag reads 1.

## Timing

- **Reset:** `i_reset_n` low immediately forces `acc = 0`, `cnt = 0`, buffer empty, `o_valid = 0`, `o_word = 0`, `o_overflow = 0`.
  - Release is synchronous to `i_clk`. The first `i_ce` after release is bit 0.
  - Reset mid-word discards the partial word and all buffered words.
- **Latency:** `o_valid` rises on the edge that samples the LN-th bit. The word is visible in the cycle after that bit's `i_ce` cycle.
- **Ordering:** words are delivered strictly in completion order. A dropped word never appears.
- **Handshake:** `o_word` is stable while `o_valid && !i_ready`. The word after a pop appears in the next cycle.
- **Throughput:** one word per LN `i_ce` cycles. With `i_ready` held high, overflow never occurs.

## Test plan

1. **Reset:** assert `i_reset_n = 0` mid-stream after 5 bits. Expect `o_valid = 0`, `o_word = 0`, `o_overflow = 0` immediately. After release, stream 8 bits of 8'h3C. Expect exactly one word, 8'h3C.
2. **Basic word:** LN=8, `i_ce = 1` every cycle, `i_ready = 1`, bits of 8'hA5 sent LSB first. Expect `o_valid = 1` for one cycle, starting the cycle after the 8th bit, with `o_word = 8'hA5`.
3. **Strobe gaps:** send 8'h96 with `i_ce` low on alternating cycles and `i_bit` toggling while `i_ce` is low. Expect `o_word = 8'h96`; the ignored bits must have no effect.
4. **Backpressure and overflow:** `i_ready = 0`, send 8'h01, 8'h02, 8'h03.
   - Expect `o_overflow = 1` and `o_word = 8'h01` held.
   - Then set `i_ready = 1`. Expect 8'h01 then 8'h02 on consecutive cycles, then `o_valid = 0`.
   - `o_overflow` stays 1 until `i_clr_ovf` pulses.
5. **Push/pop while full:** buffer full with 8'h11 and 8'h22. 8'h33 completes in the same cycle that `i_ready = 1`. Expect 8'h11 popped, `o_overflow` stays 0, and subsequent outputs 8'h22 then 8'h33.
6. **Realignment:** send 3 junk bits, then `i_sync` with `i_ce` carrying bit 0 of 8'hC3, then the remaining 7 bits. Expect a single word 8'hC3. A drop and `i_clr_ovf` in the same cycle must leave `o_overflow = 1`.

Source files
------------

// File: rtl/pipe_deser.sv
// Serial-to-parallel deserializer for the LSB-first stream from pipe.o_bit.
// Completed LN-bit words go to a 2-entry valid/ready buffer; a word that finds the buffer full is dropped and sets a sticky flag.
module pipe_deser #(
  parameter int LN = 8
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic          i_ce,
  input  logic          i_bit,
  input  logic          i_sync,
  input  logic          i_clr_ovf,
  output logic          o_valid,
  input  logic          i_ready,
  output logic [LN-1:0] o_word,
  output logic          o_overflow
);

  localparam int CW = (LN > 2) ? $clog2(LN) : 1;
  localparam logic [CW-1:0] LAST = CW'(LN - 1);

  // Only the upper LN-1 accumulator bits are stored: bit 0 is always shifted out before a word completes.
  logic [LN-2:0] r_acc;
  logic [CW-1:0] r_cnt;
  logic [LN-2:0] w_accNext;
  logic [LN-1:0] w_pushWord;
  logic          w_push;
  logic          w_pop;

  logic [LN-1:0] r_head;
  logic [LN-1:0] r_tail;
  logic [1:0]    r_count;
  logic          r_overflow;

  generate
    if (LN == 2) begin : gNarrow
      assign w_accNext = i_bit;
    end else begin : gWide
      assign w_accNext = {i_bit, r_acc[LN-2:1]};
    end
  endgenerate

  assign w_pushWord = {i_bit, r_acc};
  assign w_push     = i_ce && !i_sync && (r_cnt == LAST);
  assign w_pop      = o_valid && i_ready;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (i_sync) begin
      if (i_ce) begin
        r_acc <= w_accNext;
        r_cnt <= CW'(1);
      end else begin
        r_cnt <= '0;
      end
    end else if (i_ce) begin
      r_acc <= w_accNext;
      r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + CW'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= 2'd0;
    end else begin
      case (r_count)
        2'd0: begin
          if (w_push) begin
            r_head  <= w_pushWord;
            r_count <= 2'd1;
          end
        end
        2'd1: begin
          if (w_push && w_pop) begin
            r_head <= w_pushWord;
          end else if (w_push) begin
            r_tail  <= w_pushWord;
            r_count <= 2'd2;
          end else if (w_pop) begin
            r_count <= 2'd0;
          end
        end
        default: begin
          // A push without a pop while full is dropped; the buffer is left untouched.
          if (w_pop) begin
            r_head <= r_tail;
            if (w_push) begin
              r_tail <= w_pushWord;
            end else begin
              r_count <= 2'd1;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_overflow <= 1'b0;
    end else if (w_push && !w_pop && (r_count == 2'd2)) begin
      r_overflow <= 1'b1;
    end else if (i_clr_ovf) begin
      r_overflow <= 1'b0;
    end
  end

  assign o_valid    = (r_count != 2'd0);
  assign o_word     = o_valid ? r_head : '0;
  assign o_overflow = r_overflow;

endmodule

// File: tb/tb_pipe_deser.sv
// Scoreboard bench for pipe_deser: stimulus pushes expected words, a negedge monitor pops and compares on every handshake.
module tb_pipe_deser;

  localparam int LN = 8;

  logic          clk;
  logic          resetN;
  logic          ce;
  logic          bitIn;
  logic          sync;
  logic          clrOvf;
  logic          valid;
  logic          ready;
  logic [LN-1:0] word;
  logic          overflow;

  int checks = 0;
  int errors = 0;
  logic [LN-1:0] expQ[$];

  pipe_deser #(.LN(LN)) dut (
    .i_clk      (clk),
    .i_reset_n  (resetN),
    .i_ce       (ce),
    .i_bit      (bitIn),
    .i_sync     (sync),
    .i_clr_ovf  (clrOvf),
    .o_valid    (valid),
    .i_ready    (ready),
    .o_word     (word),
    .o_overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Inputs change 1 time unit after a rising edge and are sampled on the next one.
  task automatic applyStimulus(input logic ceV, input logic bitV, input logic syncV, input logic clrV);
    ce     = ceV;
    bitIn  = bitV;
    sync   = syncV;
    clrOvf = clrV;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic sendWord(input logic [LN-1:0] w, input logic expectIt);
    if (expectIt) expQ.push_back(w);
    for (int i = 0; i < LN; i++) applyStimulus(1'b1, w[i], 1'b0, 1'b0);
  endtask

  always @(negedge clk) begin
    if (resetN && valid && ready) begin
      checks++;
      if (expQ.size() == 0) begin
        errors++;
        $display("[TB] FAIL scoreboard: unexpected word %0h, expected none", word);
      end else begin
        logic [LN-1:0] exp;
        exp = expQ.pop_front();
        if (word !== exp) begin
          errors++;
          $display("[TB] FAIL scoreboard: got %0h, expected %0h", word, exp);
        end
      end
    end
  end

  initial begin
    logic [LN-1:0] w;
    resetN = 1'b0;
    ce = 1'b0; bitIn = 1'b0; sync = 1'b0; clrOvf = 1'b0; ready = 1'b0;
    #2;
    checkOutput("reset valid", valid, 0);
    checkOutput("reset word", word, 0);
    checkOutput("reset ovf", overflow, 0);
    @(posedge clk); #1;
    resetN = 1'b1;

    $display("[TB] reset mid-stream");
    sendWord(8'h5A, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("buffered before reset", valid, 1);
    #2 resetN = 1'b0;
    #1;
    checkOutput("async reset valid", valid, 0);
    checkOutput("async reset word", word, 0);
    checkOutput("async reset ovf", overflow, 0);
    @(posedge clk); #1;
    resetN = 1'b1;
    ready = 1'b1;
    sendWord(8'h3C, 1'b1);

    $display("[TB] basic word and latency");
    w = 8'hA5;
    for (int i = 0; i < LN - 1; i++) applyStimulus(1'b1, w[i], 1'b0, 1'b0);
    checkOutput("basic not yet valid", valid, 0);
    expQ.push_back(w);
    applyStimulus(1'b1, w[LN-1], 1'b0, 1'b0);
    checkOutput("basic valid", valid, 1);
    checkOutput("basic word", word, 32'hA5);
    idle(1);
    checkOutput("basic one cycle", valid, 0);

    $display("[TB] strobe gaps");
    w = 8'h96;
    expQ.push_back(w);
    for (int i = 0; i < LN; i++) begin
      applyStimulus(1'b1, w[i], 1'b0, 1'b0);
      applyStimulus(1'b0, ~w[i], 1'b0, 1'b0);
    end
    idle(2);

    $display("[TB] backpressure and overflow");
    ready = 1'b0;
    sendWord(8'h01, 1'b1);
    sendWord(8'h02, 1'b1);
    sendWord(8'h03, 1'b0);
    checkOutput("ovf set", overflow, 1);
    checkOutput("head held", word, 32'h01);
    idle(3);
    checkOutput("head stable", word, 32'h01);
    ready = 1'b1;
    idle(2);
    checkOutput("drained after two", valid, 0);
    checkOutput("empty word zero", word, 0);
    checkOutput("ovf sticky", overflow, 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("ovf cleared", overflow, 0);

    $display("[TB] push and pop while full");
    ready = 1'b0;
    sendWord(8'h11, 1'b1);
    sendWord(8'h22, 1'b1);
    w = 8'h33;
    expQ.push_back(w);
    for (int i = 0; i < LN - 1; i++) applyStimulus(1'b1, w[i], 1'b0, 1'b0);
    ready = 1'b1;
    applyStimulus(1'b1, w[LN-1], 1'b0, 1'b0);
    checkOutput("full push+pop no ovf", overflow, 0);
    checkOutput("full push+pop head", word, 32'h22);
    idle(3);

    $display("[TB] realignment");
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    w = 8'hC3;
    expQ.push_back(w);
    applyStimulus(1'b1, w[0], 1'b1, 1'b0);
    for (int i = 1; i < LN; i++) applyStimulus(1'b1, w[i], 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    sendWord(8'h5B, 1'b1);
    idle(2);

    $display("[TB] drop with simultaneous clear");
    ready = 1'b0;
    sendWord(8'h44, 1'b1);
    sendWord(8'h55, 1'b1);
    w = 8'h66;
    for (int i = 0; i < LN - 1; i++) applyStimulus(1'b1, w[i], 1'b0, 1'b0);
    applyStimulus(1'b1, w[LN-1], 1'b0, 1'b1);
    checkOutput("set beats clear", overflow, 1);
    ready = 1'b1;
    for (int i = 0; i < 20 && expQ.size() != 0; i++) idle(1);
    idle(1);
    checkOutput("scoreboard drained", expQ.size(), 0);
    checkOutput("final valid", valid, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("final ovf cleared", overflow, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
